// File: rtl/syst_deskew_out_if.sv
// syst_deskew_out_if: column bus from the systolic array and output stream.
// Ports: enable/psumm_i/valid_i in; data_o/valid_o out; ready_i back-pressure.
interface syst_deskew_out_if #(
  parameter int N_COLS   = 4,
  parameter int SI_WIDTH = 32,
  parameter int DO_WIDTH = 16
);
  logic                         enable;
  logic [N_COLS*SI_WIDTH-1:0]   psumm_i;
  logic [N_COLS-1:0]            valid_i;
  logic [N_COLS*DO_WIDTH-1:0]   data_o;
  logic                         valid_o;
  logic                         ready_i;

  modport slave (
    input  enable, psumm_i, valid_i, ready_i,
    output data_o, valid_o
  );

  modport master (
    output enable, psumm_i, valid_i, ready_i,
    input  data_o, valid_o
  );
endinterface

// File: rtl/syst_deskew_out.sv
// syst_deskew_out: de-skews systolic column outputs, rounds/saturates, FWFT FIFO.
// Ports: clk, rst (async high), bus (slave), clr_i, overflow_o, skew_err_o.
module syst_deskew_out #(
  parameter int N_COLS     = 4,
  parameter int SI_WIDTH   = 32,
  parameter int DO_WIDTH   = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  syst_deskew_out_if.slave  bus,
  input  logic              clr_i,
  output logic              overflow_o,
  output logic              skew_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int VW = N_COLS * DO_WIDTH;

  typedef logic signed [SI_WIDTH:0] ext_t;

  localparam ext_t ONE = ext_t'(1);
  // Half an LSB of the shifted result; zero when SHIFT is 0.
  localparam ext_t RND = (ONE <<< SHIFT) >>> 1;
  localparam ext_t HI  = (ONE <<< (DO_WIDTH - 1)) - ONE;
  localparam ext_t LO  = -(ONE <<< (DO_WIDTH - 1));

  function automatic logic [DO_WIDTH-1:0] f_rnd_sat(
    input logic [SI_WIDTH-1:0] x
  );
    ext_t s;
    s = ext_t'($signed(x)) + RND;
    s = s >>> SHIFT;
    if (s > HI)      return DO_WIDTH'(HI);
    else if (s < LO) return DO_WIDTH'(LO);
    else             return DO_WIDTH'(s);
  endfunction

  logic [SI_WIDTH-1:0] w_ax [N_COLS];
  logic [N_COLS-1:0]   w_av;

  // Column k waits N_COLS-1-k enabled cycles so all columns line up.
  for (genvar k = 0; k < N_COLS; k++) begin : g_col
    localparam int D = N_COLS - 1 - k;
    if (D == 0) begin : g_thru
      assign w_ax[k] = bus.psumm_i[k*SI_WIDTH +: SI_WIDTH];
      assign w_av[k] = bus.valid_i[k];
    end else begin : g_dly
      logic [SI_WIDTH-1:0] r_d [D];
      logic [D-1:0]        r_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_v <= '0;
        else if (bus.enable)
          r_v <= D'({r_v, bus.valid_i[k]});
      end

      always_ff @(posedge clk) begin
        if (bus.enable) begin
          r_d[0] <= bus.psumm_i[k*SI_WIDTH +: SI_WIDTH];
          for (int i = 1; i < D; i++)
            r_d[i] <= r_d[i-1];
        end
      end

      assign w_ax[k] = r_d[D-1];
      assign w_av[k] = r_v[D-1];
    end
  end

  logic w_all;
  logic w_any;
  logic w_vld;
  logic w_skew;

  assign w_all  = &w_av;
  assign w_any  = |w_av;
  // A stalled cycle never produces a vector or a skew event.
  assign w_vld  = bus.enable & w_all;
  assign w_skew = bus.enable & w_any & ~w_all;

  logic [VW-1:0] w_rs;
  logic [VW-1:0] r_rd;
  logic          r_rv;

  always_comb begin
    w_rs = '0;
    for (int k = 0; k < N_COLS; k++)
      w_rs[k*DO_WIDTH +: DO_WIDTH] = f_rnd_sat(w_ax[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rv <= 1'b0;
    else     r_rv <= w_vld;
  end

  always_ff @(posedge clk) begin
    r_rd <= w_rs;
  end

  logic [VW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = ~w_empty & bus.ready_i;
  // A pop in the same cycle frees the slot the write needs.
  assign w_push  = r_rv & (~w_full | w_pop);
  assign w_drop  = r_rv & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= r_rd;
  end

  assign bus.valid_o = ~w_empty;
  assign bus.data_o  = r_mem[r_rp[AW-1:0]];

  logic r_ovf;
  logic r_skw;

  // New events win over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_skw <= 1'b0;
    end else begin
      r_ovf <= w_drop | (r_ovf & ~clr_i);
      r_skw <= w_skew | (r_skw & ~clr_i);
    end
  end

  assign overflow_o = r_ovf;
  assign skew_err_o = r_skw;
endmodule
